wb_gpio_irq: RTL and testbench
==============================

Name: wb_gpio_irq

Overview:
Parametrised Wishbone GPIO slave, successor to the single-register LED/switch port. It provides LED output bits, synchronised switch inputs, and PB_N debounced active-low pushbuttons. Each pushbutton has per-channel edge-event capture, masking and a combined interrupt request. It sits on the 16-bit peripheral Wishbone bus; irq_o feeds the interrupt controller and pb_db_o[0] is used as the NMI source.

Parameters:
LED_W, 8, LED output count (1..16)
SW_W, 8, switch input count (1..16)
PB_N, 4, pushbutton channel count (1..16)
DB_W, 3, debounce counter width; lockout = 2^DB_W-1 tick pulses

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  reset, asynchronous, active-high
wb_adr_i  in  3  word address
wb_dat_i  in  16  write data
wb_dat_o  out  16  read data, registered
wb_sel_i  in  2  byte enables (bit0 = [7:0], bit1 = [15:8])
wb_we_i  in  1  write enable
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_ack_o  out  1  acknowledge, registered
leds_o  out  LED_W  LED register
sw_i  in  SW_W  raw switches, asynchronous
pb_i  in  PB_N  raw pushbuttons, active-low, asynchronous
tick_i  in  1  slow timebase; the rising edge counts
pb_db_o  out  PB_N  debounced levels, 1 = pressed
irq_o  out  1  OR of pending & mask, registered

Behaviour:
- Reset (async, wb_rst_i=1) values: leds_o=0, wb_dat_o=0, wb_ack_o=0, irq_o=0, pb_db_o=0, PEND=0, MASK=0, EDGE=0, all sync flops=0, tick_old=0, all debounce counters=all-ones (armed).
- Bus request: req = wb_cyc_i & wb_stb_i & ~wb_ack_o.
  - On a clock edge with req=1: wb_ack_o<=1, the write is applied, and wb_dat_o is loaded.
  - Next edge: wb_ack_o<=0.
  - Result: a 1-wait-state ack; back-to-back requests take 2 cycles each. A write is applied exactly once per ack.
  - Write bytes are gated by wb_sel_i. Register bits beyond the parameter width ignore writes and read 0.
- Register map (wb_adr_i):
  - 0 SW: RO, 2-flop synchronised sw_i.
  - 1 LED: RW, drives leds_o.
  - 2 PB: RO, pb_db_o.
  - 3 PEND: read gives pending; writing 1 to a bit clears it (W1C).
  - 4 MASK: RW.
  - 5 EDGE: RW; bit=0 → event on press only, bit=1 → event on press and release.
  - 6, 7: read 0, writes ignored.
- Input synchronisation:
  - pb_i is inverted, then passed through a 2-flop sync giving pb_s.
  - tick_i is 2-flop synced; tick_p = tick_s & ~tick_old is a 1-cycle pulse.
- Debounce, per channel n, counter cnt[n]:
  - If cnt=all-ones and pb_s[n]!=pb_db_o[n]: pb_db_o[n]<=pb_s[n] and cnt<=0.
  - Else if cnt!=all-ones and tick_p: cnt<=cnt+1.
  - Otherwise hold.
  - Result: the first change is taken immediately, then further changes are ignored for 2^DB_W-1 tick pulses. The counter never wraps.
- Events:
  - A 0→1 transition of pb_db_o[n] sets PEND[n].
  - A 1→0 transition sets PEND[n] only if EDGE[n]=1.
  - If a set and a W1C clear of the same bit occur in the same cycle, the set wins.
  - PEND bits are set regardless of MASK.
- irq_o <= |(PEND & MASK), registered, so it follows the register state by 1 cycle.
  - Unmasking an already-pending bit raises irq_o 1 cycle after the write edge.
- Reset asserted mid-transaction: everything returns to reset values immediately and the ack is dropped. No write is applied unless its edge has already occurred.

Test Plan:
- Reset, then read addr 0 with sw_i=8'hA5 → ack exactly 1 cycle after the request; dat_o=16'h00A5. Each read takes 2 cycles.
- Write 16'hBEEF to addr 1 with sel=2'b01 (LED_W=8) → leds_o=8'hEF; readback returns 16'h00EF. A write with sel=2'b10 leaves leds_o unchanged.
- pb_i[1] bounces (low, high, low within 3 ticks), DB_W=3 → pb_db_o[1] rises on the first low (+2 sync cycles) and ignores the bounce. The release is accepted only after 7 tick pulses.
- MASK=4'b0010, EDGE=0; press then release pb 1 → PEND=4'b0010 after the press only; irq_o=1 one cycle later. W1C 16'h0002 → PEND=0, then irq_o=0 on the following cycle.
- EDGE[2]=1, MASK=0; press and release pb 2 → PEND[2] set and irq_o stays 0. Writing MASK=4'b0100 → irq_o=1 one cycle after the ack edge.
- W1C of PEND[0] in the same cycle as a new press on channel 0 → PEND[0] remains 1. Asserting reset mid-ack → wb_ack_o, leds_o, PEND and irq_o go to 0 asynchronously.

Source files
------------

// File: rtl/wb_gpio_irq_if.sv
// Wishbone slave bus bundle for wb_gpio_irq; handshake is stb/cyc in, ack out.
// Single-beat, one wait state per access; no stall signal.
interface wb_gpio_irq_if;
    logic [2:0]  wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_gpio_irq.sv
// GPIO slave: LEDs, synced switches, debounced pushbuttons with edge events and masked IRQ.
// Bus ack 1 cycle after request, 2 cycles per access; the slave never stalls beyond that.
module wb_gpio_irq #(
    parameter int LED_W = 8,
    parameter int SW_W  = 8,
    parameter int PB_N  = 4,
    parameter int DB_W  = 3
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_gpio_irq_if.slave      bus,
    output logic [LED_W-1:0]  leds_o,
    input  logic [SW_W-1:0]   sw_i,
    input  logic [PB_N-1:0]   pb_i,
    input  logic              tick_i,
    output logic [PB_N-1:0]   pb_db_o,
    output logic              irq_o
);
    localparam logic [DB_W-1:0] CNT_MAX = '1;

    logic [LED_W-1:0] r_leds;
    logic [SW_W-1:0]  r_sw_s1, r_sw_s2;
    logic [PB_N-1:0]  r_pb_s1, r_pb_s2;
    logic             r_tick_s1, r_tick_s2, r_tick_old;
    logic [DB_W-1:0]  r_cnt [PB_N];
    logic [PB_N-1:0]  r_db, r_pend, r_mask, r_edge;
    logic [15:0]      r_dat;
    logic             r_ack, r_irq;

    logic             w_req, w_wr, w_tick_p;
    logic [15:0]      w_be, w_rdat;
    logic [PB_N-1:0]  w_db_nx, w_set, w_clr;

    function automatic logic [15:0] merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                          input logic [15:0] be);
        return (old_v & ~be) | (new_v & be);
    endfunction

    assign w_req    = bus.wb_cyc_i & bus.wb_stb_i & ~r_ack;
    assign w_wr     = w_req & bus.wb_we_i;
    assign w_be     = {{8{bus.wb_sel_i[1]}}, {8{bus.wb_sel_i[0]}}};
    assign w_tick_p = r_tick_s2 & ~r_tick_old;

    always_comb begin
        w_rdat = '0;
        case (bus.wb_adr_i)
            3'd0:    w_rdat = 16'(r_sw_s2);
            3'd1:    w_rdat = 16'(r_leds);
            3'd2:    w_rdat = 16'(r_db);
            3'd3:    w_rdat = 16'(r_pend);
            3'd4:    w_rdat = 16'(r_mask);
            3'd5:    w_rdat = 16'(r_edge);
            default: w_rdat = '0;
        endcase
    end

    // A changed input is taken only while the channel's lockout counter sits at all-ones.
    always_comb begin
        w_db_nx = r_db;
        for (int n = 0; n < PB_N; n++) begin
            if (r_cnt[n] == CNT_MAX && r_pb_s2[n] != r_db[n]) begin
                w_db_nx[n] = r_pb_s2[n];
            end
        end
    end

    assign w_set = (w_db_nx & ~r_db) | (~w_db_nx & r_db & r_edge);
    assign w_clr = (w_wr && bus.wb_adr_i == 3'd3) ? PB_N'(bus.wb_dat_i & w_be) : '0;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_leds     <= '0;
            r_sw_s1    <= '0;
            r_sw_s2    <= '0;
            r_pb_s1    <= '0;
            r_pb_s2    <= '0;
            r_tick_s1  <= 1'b0;
            r_tick_s2  <= 1'b0;
            r_tick_old <= 1'b0;
            r_db       <= '0;
            r_pend     <= '0;
            r_mask     <= '0;
            r_edge     <= '0;
            r_dat      <= '0;
            r_ack      <= 1'b0;
            r_irq      <= 1'b0;
            for (int n = 0; n < PB_N; n++) begin
                r_cnt[n] <= CNT_MAX;
            end
        end else begin
            r_sw_s1    <= sw_i;
            r_sw_s2    <= r_sw_s1;
            r_pb_s1    <= ~pb_i;
            r_pb_s2    <= r_pb_s1;
            r_tick_s1  <= tick_i;
            r_tick_s2  <= r_tick_s1;
            r_tick_old <= r_tick_s2;

            r_ack <= w_req;
            if (w_req) begin
                r_dat <= w_rdat;
            end

            if (w_wr && bus.wb_adr_i == 3'd1) begin
                r_leds <= LED_W'(merge(16'(r_leds), bus.wb_dat_i, w_be));
            end
            if (w_wr && bus.wb_adr_i == 3'd4) begin
                r_mask <= PB_N'(merge(16'(r_mask), bus.wb_dat_i, w_be));
            end
            if (w_wr && bus.wb_adr_i == 3'd5) begin
                r_edge <= PB_N'(merge(16'(r_edge), bus.wb_dat_i, w_be));
            end

            // A new event beats a simultaneous software clear.
            r_pend <= (r_pend & ~w_clr) | w_set;
            r_irq  <= |(r_pend & r_mask);
            r_db   <= w_db_nx;

            for (int n = 0; n < PB_N; n++) begin
                if (r_cnt[n] == CNT_MAX && r_pb_s2[n] != r_db[n]) begin
                    r_cnt[n] <= '0;
                end else if (r_cnt[n] != CNT_MAX && w_tick_p) begin
                    r_cnt[n] <= r_cnt[n] + 1'b1;
                end
            end
        end
    end

    assign leds_o       = r_leds;
    assign pb_db_o      = r_db;
    assign irq_o        = r_irq;
    assign bus.wb_dat_o = r_dat;
    assign bus.wb_ack_o = r_ack;
endmodule

// File: tb/tb_wb_gpio_irq.sv
// Self-checking bench for wb_gpio_irq: directed steps then randomized traffic vs a behavioural model.
module tb_wb_gpio_irq;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw;
    logic [3:0] pb;
    logic       tick;
    logic [7:0] leds;
    logic [3:0] pb_db;
    logic       irq;

    wb_gpio_irq_if bus ();

    wb_gpio_irq #(.LED_W(8), .SW_W(8), .PB_N(4), .DB_W(3)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus.slave),
        .leds_o   (leds),
        .sw_i     (sw),
        .pb_i     (pb),
        .tick_i   (tick),
        .pb_db_o  (pb_db),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Behavioural model: register contents plus per-button "ticks left in lockout".
    logic [7:0] m_sw, m_leds;
    logic [3:0] m_pend, m_mask, m_edge, m_db, m_press;
    int         m_lock [4];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic m_irq();
        return |(m_pend & m_mask);
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] adr);
        case (adr)
            3'd0: return {8'h00, m_sw};
            3'd1: return {8'h00, m_leds};
            3'd2: return {12'h000, m_db};
            3'd3: return {12'h000, m_pend};
            3'd4: return {12'h000, m_mask};
            3'd5: return {12'h000, m_edge};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic m_reset();
        m_leds = '0; m_pend = '0; m_mask = '0; m_edge = '0; m_db = '0;
        for (int n = 0; n < 4; n++) m_lock[n] = 0;
    endtask

    task automatic accept(input int n);
        if (m_lock[n] == 0 && m_press[n] != m_db[n]) begin
            if (m_press[n] || m_edge[n]) m_pend[n] = 1'b1;
            m_db[n]   = m_press[n];
            m_lock[n] = 7;
        end
    endtask

    task automatic wb_write(input logic [2:0] adr, input logic [15:0] dat, input logic [1:0] sel,
                            input logic [3:0] setm);
        logic irq_old;
        irq_old = m_irq();
        @(negedge clk);
        bus.wb_adr_i = adr; bus.wb_dat_i = dat; bus.wb_sel_i = sel;
        bus.wb_we_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        @(posedge clk); #1;
        chk("wr_ack", 16'(bus.wb_ack_o), 16'h1);
        chk("wr_irq_at_ack", 16'(irq), 16'(irq_old));
        if (sel[0]) begin
            case (adr)
                3'd1: m_leds = dat[7:0];
                3'd3: m_pend = m_pend & ~dat[3:0];
                3'd4: m_mask = dat[3:0];
                3'd5: m_edge = dat[3:0];
                default: ;
            endcase
        end
        m_pend = m_pend | setm;
        @(negedge clk);
        bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        @(posedge clk); #1;
        chk("wr_ack_drop", 16'(bus.wb_ack_o), 16'h0);
        chk("wr_irq_next", 16'(irq), 16'(m_irq()));
        chk("wr_leds", 16'(leds), 16'(m_leds));
    endtask

    task automatic wb_read(input logic [2:0] adr, input string tag);
        logic [15:0] exp;
        exp = m_read(adr);
        @(negedge clk);
        bus.wb_adr_i = adr; bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_ack"}, 16'(bus.wb_ack_o), 16'h1);
        chk(tag, bus.wb_dat_o, exp);
        @(negedge clk);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_ack_drop"}, 16'(bus.wb_ack_o), 16'h0);
    endtask

    // Button level change: debounced output may move exactly 3 edges after the raw change.
    task automatic set_pb(input int n, input logic pressed);
        @(negedge clk);
        pb[n] = ~pressed;
        m_press[n] = pressed;
        repeat (2) @(posedge clk);
        #1 chk("pb_lat2", 16'(pb_db), 16'(m_db));
        @(posedge clk); #1;
        accept(n);
        chk("pb_lat3", 16'(pb_db), 16'(m_db));
        repeat (2) @(posedge clk);
        #1;
        chk("pb_settled", 16'(pb_db), 16'(m_db));
        chk("pb_irq", 16'(irq), 16'(m_irq()));
    endtask

    task automatic do_tick();
        @(negedge clk); tick = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); tick = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++) begin
            if (m_lock[n] > 0) m_lock[n]--;
            accept(n);
        end
        chk("tick_db", 16'(pb_db), 16'(m_db));
        chk("tick_irq", 16'(irq), 16'(m_irq()));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rnd;
        int          op, ch;

        rst = 1'b1; sw = 8'h00; pb = 4'hF; tick = 1'b0;
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
        bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        m_sw = '0; m_press = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_leds", 16'(leds), 16'h0);
        chk("rst_ack", 16'(bus.wb_ack_o), 16'h0);
        chk("rst_dat", bus.wb_dat_o, 16'h0);
        chk("rst_irq", 16'(irq), 16'h0);
        chk("rst_pbdb", 16'(pb_db), 16'h0);
        @(negedge clk); rst = 1'b0;

        // Switch read and ack cadence.
        sw = 8'hA5; m_sw = 8'hA5;
        repeat (3) @(posedge clk);
        wb_read(3'd0, "rd_sw");
        @(negedge clk);
        bus.wb_adr_i = 3'd0; bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("b2b_ack", 16'(bus.wb_ack_o), (i % 2 == 0) ? 16'h1 : 16'h0);
        end
        @(negedge clk); bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;

        // Byte-lane gated LED writes.
        wb_write(3'd1, 16'hBEEF, 2'b01, 4'h0);
        chk("led_ef", 16'(leds), 16'h00EF);
        wb_read(3'd1, "rd_led");
        wb_write(3'd1, 16'h1234, 2'b10, 4'h0);
        chk("led_hi_sel", 16'(leds), 16'h00EF);

        // Bounce on button 1 with press-only events.
        wb_write(3'd4, 16'h0002, 2'b11, 4'h0);
        set_pb(1, 1'b1);
        chk("pend_press", 16'(m_pend), 16'h0002);
        do_tick();
        set_pb(1, 1'b0);
        do_tick();
        set_pb(1, 1'b1);
        set_pb(1, 1'b0);
        repeat (7) do_tick();
        chk("release_taken", 16'(pb_db[1]), 16'h0);
        wb_read(3'd3, "rd_pend1");
        wb_write(3'd3, 16'h0002, 2'b01, 4'h0);
        wb_read(3'd3, "rd_pend1_clr");

        // Both-edge events on button 2, then unmask an already-pending bit.
        wb_write(3'd5, 16'h0004, 2'b01, 4'h0);
        wb_write(3'd4, 16'h0000, 2'b01, 4'h0);
        set_pb(2, 1'b1);
        wb_write(3'd3, 16'h0004, 2'b01, 4'h0);
        set_pb(2, 1'b0);
        repeat (7) do_tick();
        wb_read(3'd3, "rd_pend2_release");
        wb_write(3'd4, 16'h0004, 2'b01, 4'h0);
        chk("unmask_irq", 16'(irq), 16'h1);

        // Clear and new press on button 0 land on the same edge.
        set_pb(0, 1'b1);
        set_pb(0, 1'b0);
        repeat (14) do_tick();
        @(negedge clk); pb[0] = 1'b0; m_press[0] = 1'b1;
        repeat (2) @(posedge clk);
        wb_write(3'd3, 16'h0001, 2'b01, 4'b0001);
        accept(0);
        wb_read(3'd3, "rd_pend_setwins");
        wb_read(3'd2, "rd_pb");

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            op  = $urandom_range(0, 7);
            rnd = 16'($urandom);
            ch  = $urandom_range(0, 3);
            case (op)
                0: begin
                    sw = rnd[7:0]; m_sw = rnd[7:0];
                    repeat (3) @(posedge clk);
                    wb_read(3'd0, "r_sw");
                end
                1: begin
                    wb_write(3'd1, rnd, 2'($urandom), 4'h0);
                    wb_read(3'd1, "r_led");
                end
                2: set_pb(ch, ~m_press[ch]);
                3: do_tick();
                4: begin
                    wb_write(3'd4, rnd, 2'($urandom), 4'h0);
                    wb_read(3'd4, "r_mask");
                end
                5: begin
                    wb_write(3'd5, rnd, 2'($urandom), 4'h0);
                    wb_read(3'd5, "r_edge");
                end
                6: begin
                    wb_write(3'd3, rnd, 2'($urandom), 4'h0);
                    wb_read(3'd3, "r_pend");
                end
                default: begin
                    wb_write(3'(6 + (ch % 2)), rnd, 2'b11, 4'h0);
                    wb_read(3'(6 + (ch % 2)), "r_unused");
                    wb_read(3'd2, "r_pb");
                end
            endcase
        end

        // Reset in the middle of an ack with an interrupt pending.
        wb_write(3'd5, 16'h000F, 2'b01, 4'h0);
        wb_write(3'd4, 16'h000F, 2'b01, 4'h0);
        repeat (8) do_tick();
        set_pb(3, ~m_press[3]);
        chk("pre_rst_irq", 16'(irq), 16'h1);
        @(negedge clk);
        bus.wb_adr_i = 3'd1; bus.wb_dat_i = 16'h005A; bus.wb_sel_i = 2'b01;
        bus.wb_we_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_ack", 16'(bus.wb_ack_o), 16'h1);
        chk("pre_rst_leds", 16'(leds), 16'h005A);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_ack", 16'(bus.wb_ack_o), 16'h0);
        chk("mid_rst_leds", 16'(leds), 16'h0);
        chk("mid_rst_irq", 16'(irq), 16'h0);
        chk("mid_rst_pbdb", 16'(pb_db), 16'h0);
        bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        pb = 4'hF; m_press = '0;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        wb_read(3'd3, "post_rst_pend");
        wb_read(3'd4, "post_rst_mask");
        wb_read(3'd1, "post_rst_led");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
